pipelined_barrel_shifter: RTL
=============================

// Module: pipelined_barrel_shifter
// PURPOSE
//  Parametrised, pipelined barrel shifter for the execute stage.
//  Supports logical left, logical right, arithmetic right and rotate right.
//  Operands arrive on a valid/ready stream and results leave on a valid/ready stream.
//  Shift levels are log2(WIDTH) mux levels, split across NUM_REGS register stages.
//  Latency: NUM_REGS cycles; full throughput of one op per cycle.
// PARAMETERS
//  WIDTH     64  data width; power of 2, 8..128
//  NUM_REGS  2   pipeline register stages, 1..log2(WIDTH)
//  SHW       -   localparam = $clog2(WIDTH), shift-amount width
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      input operation valid
//  in_ready   out  1      block can accept an input this cycle
//  in_data    in   WIDTH  operand
//  in_shamt   in   SHW    shift amount, 0..WIDTH-1
//  in_op      in   2      00 SLL, 01 SRL, 10 SRA, 11 ROR
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts the result
//  out_data   out  WIDTH  result
//  busy       out  1      OR of all stage valid bits
//  out_zero   out  1      (FLAGS_EN only) result == 0
//  out_carry  out  1      (FLAGS_EN only) last bit shifted out
// BEHAVIOUR
//  - Mux level k shifts by 2^k when shamt[k]=1, for k = 0..SHW-1.
//  - Level k sits in register stage s = floor(k*NUM_REGS/SHW).
//  - Each stage register holds: valid, partial data, remaining shamt bits, op, and the sign bit captured at input.
//  - Fill bits:
//    - SLL and SRL fill with 0.
//    - SRA fills with the original in_data[WIDTH-1], taken from the captured sign, not the partial MSB.
//    - ROR wraps: bits leaving bit 0 enter at bit WIDTH-1.
//  - in_shamt = 0 gives out_data = in_data for every op.
//  - Handshake:
//    - Stage i advances when !valid_i || ready_(i+1).
//    - in_ready = !valid_0 || ready_1; this is combinational, so there are no bubbles.
//    - out_valid = valid of the last stage.
//    - An input transfers when in_valid && in_ready.
//    - An output transfers when out_valid && out_ready.
//  - Stall: while out_valid && !out_ready, out_data, out_valid and the flags hold stable.
//    - Upstream stages keep filling until every stage is full, then in_ready drops.
//  - Simultaneous output transfer and new input on a full pipe: both happen in the same cycle, with no lost or duplicated ops.
//  - Ordering: results leave in strict input order.
//  - Reset (asynchronous, mid-operation included):
//    - All stage valid bits clear; in-flight ops are discarded.
//    - out_valid=0, out_data=0, busy=0.
//    - in_ready=1 while no stage holds data.
//    - With FLAGS_EN: out_zero=0, out_carry=0.
//  - Data registers also reset to 0, so the outputs are deterministic after reset.
// CONFIGURATION
//  - SHIFTER_FLAGS_EN defined: out_zero and out_carry ports exist.
//    - Carry is tracked per stage.
//      - SLL: in_data[WIDTH-shamt].
//      - SRL and SRA: in_data[shamt-1].
//      - ROR: out_data[WIDTH-1].
//      - shamt = 0: carry = 0.
//    - out_zero is registered with out_data in the final stage.
//  - SHIFTER_FLAGS_EN undefined: the flag ports and flag logic are absent; everything else is identical.
// TESTING
//  (WIDTH=64, NUM_REGS=2 unless stated otherwise)
//  - SRA: 0x8000_0000_0000_0000, shamt 63 -> 0xFFFF_FFFF_FFFF_FFFF after exactly 2 cycles.
//    - FLAGS_EN: carry 0, zero 0.
//  - SRL: 0xF000_0000_0000_0001, shamt 4 -> 0x0F00_0000_0000_0000; FLAGS_EN: carry 0.
//  - SLL: 0x1, shamt 63 -> 0x8000_0000_0000_0000.
//  - ROR: 0x1, shamt 1 -> 0x8000_0000_0000_0000; FLAGS_EN: carry 1.
//  - Back-to-back stall:
//    - Stimulus: issue 5 ops on consecutive cycles, hold out_ready=0 for 4 cycles, then release it.
//    - Response: in_ready drops after 2 accepts, out_data holds stable, and all 5 results emerge in order with none lost.
//  - Reset mid-flight:
//    - Stimulus: 2 ops in the pipe, pulse rst_n low asynchronously between clock edges.
//    - Response: out_valid=0 and busy=0 immediately; no stale result appears after reset.
//  - Randomised sweep, all ops:
//    - Each result is checked against >>>, >>, << and rotate reference models.
//    - Run at NUM_REGS = 1, 3 and 6, and at WIDTH=8.

Source files
------------

// File: rtl/pipelined_barrel_shifter_if.sv
// Valid/ready operand and result streams for pipelined_barrel_shifter.
// Optional flag signals exist only when SHIFTER_FLAGS_EN is defined.
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH = 64
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
`ifdef SHIFTER_FLAGS_EN
  logic             out_zero;
  logic             out_carry;
`endif

  modport master (
    output in_valid,
    output in_data,
    output in_shamt,
    output in_op,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
`ifdef SHIFTER_FLAGS_EN
    input  out_zero,
    input  out_carry,
`endif
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_shamt,
    input  in_op,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
`ifdef SHIFTER_FLAGS_EN
    output out_zero,
    output out_carry,
`endif
    output busy
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROR, log2(WIDTH) mux levels split
// over NUM_REGS registered stages. Ports: clk, rst_n (async, active-low),
// io (slave: in_* operand stream, out_* result stream, busy).
// SHIFTER_FLAGS_EN adds registered out_zero / out_carry.
module pipelined_barrel_shifter #(
  parameter int WIDTH    = 64,
  parameter int NUM_REGS = 2
) (
  input logic clk,
  input logic rst_n,
  pipelined_barrel_shifter_if.slave io
);
  localparam int SHW = $clog2(WIDTH);
  localparam int L   = NUM_REGS - 1;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   sh;
    logic [1:0]       op;
    logic             sgn;
`ifdef SHIFTER_FLAGS_EN
    logic             cy;
`endif
  } stg_t;

  logic [NUM_REGS-1:0] v_q;
  logic [NUM_REGS-1:0] v_in;
  logic [NUM_REGS-1:0] adv;
  stg_t                q   [NUM_REGS];
  stg_t                src [NUM_REGS];
  stg_t                nxt [NUM_REGS];
`ifdef SHIFTER_FLAGS_EN
  logic                z_q;
`endif

  // One mux level: shift by n with op-specific fill.
  // SRA fill uses the sign captured at input, not the partial MSB.
  function automatic logic [WIDTH-1:0] lvl(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic             sgn,
    input int               n
  );
    logic [WIDTH-1:0] fill;
    fill = sgn ? ~({WIDTH{1'b1}} >> n) : '0;
    case (op)
      2'b00:   lvl = d << n;
      2'b01:   lvl = d >> n;
      2'b10:   lvl = (d >> n) | fill;
      default: lvl = (d >> n) | (d << (WIDTH - n));
    endcase
  endfunction

  // Stage s may load if any stage from s to the end is empty or
  // the output is being taken; avoids a self-referencing chain.
  always_comb begin
    for (int s = 0; s < NUM_REGS; s++) begin
      logic a;
      a = io.out_ready;
      for (int j = 0; j < NUM_REGS; j++) begin
        if (j >= s && !v_q[j]) a = 1'b1;
      end
      adv[s] = a;
    end
  end

  always_comb begin
    src[0].data = io.in_data;
    src[0].sh   = io.in_shamt;
    src[0].op   = io.in_op;
    src[0].sgn  = io.in_data[WIDTH-1];
`ifdef SHIFTER_FLAGS_EN
    src[0].cy   = 1'b0;
`endif
    v_in[0] = io.in_valid;
    for (int s = 1; s < NUM_REGS; s++) begin
      src[s]  = q[s-1];
      v_in[s] = v_q[s-1];
    end
  end

  // Level k lives in stage floor(k*NUM_REGS/SHW).
  always_comb begin
    for (int s = 0; s < NUM_REGS; s++) begin
      nxt[s] = src[s];
      for (int k = 0; k < SHW; k++) begin
        if ((k * NUM_REGS) / SHW == s && src[s].sh[k]) begin
`ifdef SHIFTER_FLAGS_EN
          // Last bit leaving at this level; ROR's equals new MSB.
          nxt[s].cy = (src[s].op == 2'b00)
            ? nxt[s].data[SHW'(WIDTH - (1 << k))]
            : nxt[s].data[SHW'((1 << k) - 1)];
`endif
          nxt[s].data = lvl(nxt[s].data, nxt[s].op,
                            nxt[s].sgn, 1 << k);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int s = 0; s < NUM_REGS; s++) q[s] <= '0;
`ifdef SHIFTER_FLAGS_EN
      z_q <= 1'b0;
`endif
    end else begin
      for (int s = 0; s < NUM_REGS; s++) begin
        if (adv[s]) begin
          v_q[s] <= v_in[s];
          if (v_in[s]) q[s] <= nxt[s];
        end
      end
`ifdef SHIFTER_FLAGS_EN
      if (adv[L] && v_in[L]) z_q <= (nxt[L].data == '0);
`endif
    end
  end

  assign io.in_ready  = adv[0];
  assign io.out_valid = v_q[L];
  assign io.out_data  = q[L].data;
  assign io.busy      = |v_q;
`ifdef SHIFTER_FLAGS_EN
  assign io.out_carry = q[L].cy;
  assign io.out_zero  = z_q;
`endif
endmodule
